exc_ctrl: RTL and testbench

- Exception/interrupt sequencer for the P7 pipeline. It sits between the M-stage pipeline register and the CP0 register file.
- Decides each cycle whether the M-stage instruction traps, takes an interrupt or retires an eret.
- Drives CP0's exception code, PC and delay-slot inputs, gates CP0/memory writes, clears EXL on eret, and flushes the pipeline with a PC redirect to the handler or to EPC.

---
 rtl/exc_pkg.sv | 11 +
 rtl/exc_ctrl_if.sv | 34 +++
 rtl/exc_prio.sv | 20 ++
 rtl/exc_ctrl.sv | 113 +++++++++++
 tb/tb_exc_ctrl.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/exc_pkg.sv
// Shared definitions for the exception sequencer: ExcCodes, default vector, FSM encoding.
package exc_pkg;
  localparam logic [4:0]  EXC_INT  = 5'd0;
  localparam logic [4:0]  EXC_ADEL = 5'd4;
  localparam logic [4:0]  EXC_ADES = 5'd5;
  localparam logic [4:0]  EXC_RI   = 5'd10;
  localparam logic [4:0]  EXC_OV   = 5'd12;
  localparam logic [31:0] EXC_HANDLER_DEF = 32'h0000_4180;

  typedef enum logic {ST_RUN = 1'b0, ST_FLUSH = 1'b1} state_e;
endpackage

// File: rtl/exc_ctrl_if.sv
// M-stage / CP0 / pipeline-control bundle around exc_ctrl.
interface exc_ctrl_if;
  logic        m_valid;
  logic [31:0] m_pc;
  logic        m_bd;
  logic        m_exc_valid;
  logic [4:0]  m_exc_code;
  logic        m_eret;
  logic        m_mtc0;
  logic        irq_pend;
  logic [31:0] cp0_epc;
  logic [5:0]  cp0_exc;
  logic [31:0] cp0_pc;
  logic        cp0_bd;
  logic        cp0_take;
  logic        cp0_we_ok;
  logic        exl_clr;
  logic        mem_kill;
  logic        flush;
  logic        redirect;
  logic [31:0] redirect_pc;

  // master = pipeline/CP0 side, slave = the sequencer
  modport master (
    output m_valid, m_pc, m_bd, m_exc_valid, m_exc_code, m_eret, m_mtc0, irq_pend, cp0_epc,
    input  cp0_exc, cp0_pc, cp0_bd, cp0_take, cp0_we_ok, exl_clr, mem_kill, flush,
           redirect, redirect_pc
  );
  modport slave (
    input  m_valid, m_pc, m_bd, m_exc_valid, m_exc_code, m_eret, m_mtc0, irq_pend, cp0_epc,
    output cp0_exc, cp0_pc, cp0_bd, cp0_take, cp0_we_ok, exl_clr, mem_kill, flush,
           redirect, redirect_pc
  );
endinterface

// File: rtl/exc_prio.sv
// Combinational trap pick: interrupt beats the instruction's own exception.
module exc_prio
  import exc_pkg::*;
(
  input  logic       m_valid,
  input  logic       irq_pend,
  input  logic       m_exc_valid,
  input  logic [4:0] m_exc_code,
  output logic       trap,
  output logic [5:0] cp0_exc,
  output logic       take_int,
  output logic       take_exc
);
  always_comb begin
    trap     = m_valid & (irq_pend | m_exc_valid);
    take_int = trap & irq_pend;
    take_exc = trap & ~irq_pend;
    cp0_exc  = take_exc ? {1'b1, m_exc_code} : {1'b0, EXC_INT};
  end
endmodule

// File: rtl/exc_ctrl.sv
// Exception/interrupt/eret sequencer between M stage and CP0.
// Optional EXC_STATS_EN adds saturating interrupt/exception take counters.
module exc_ctrl
  import exc_pkg::*;
#(
  parameter logic [31:0] HANDLER_ADDR = EXC_HANDLER_DEF,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  exc_ctrl_if.slave   bus
`ifdef EXC_STATS_EN
  ,
  output logic [15:0] int_cnt,
  output logic [15:0] exc_cnt
`endif
);
  localparam logic [2:0] FC = 3'(FLUSH_CYCLES);

  state_e     state, state_nxt;
  logic [2:0] cnt, cnt_nxt;
  logic       trap, take_int, take_exc, eret_ret, run;
  logic [5:0] pick_exc;

  exc_prio u_prio (
    .m_valid     (bus.m_valid),
    .irq_pend    (bus.irq_pend),
    .m_exc_valid (bus.m_exc_valid),
    .m_exc_code  (bus.m_exc_code),
    .trap        (trap),
    .cp0_exc     (pick_exc),
    .take_int    (take_int),
    .take_exc    (take_exc)
  );

  assign run      = (state == ST_RUN) & ~reset;
  assign eret_ret = bus.m_valid & bus.m_eret & ~trap;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    bus.cp0_exc     = '0;
    bus.cp0_pc      = '0;
    bus.cp0_bd      = 1'b0;
    bus.cp0_take    = 1'b0;
    bus.cp0_we_ok   = 1'b0;
    bus.exl_clr     = 1'b0;
    bus.mem_kill    = 1'b0;
    bus.flush       = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = HANDLER_ADDR;
    if (!reset) begin
      case (state)
        ST_RUN: begin
          bus.cp0_pc = bus.m_pc;
          bus.cp0_bd = bus.m_bd;
          if (trap) begin
            bus.cp0_exc  = pick_exc;
            bus.cp0_take = 1'b1;
            bus.mem_kill = 1'b1;
            bus.flush    = 1'b1;
            bus.redirect = 1'b1;
          end else if (eret_ret) begin
            bus.exl_clr     = 1'b1;
            bus.flush       = 1'b1;
            bus.redirect    = 1'b1;
            bus.redirect_pc = bus.cp0_epc;
          end else begin
            bus.cp0_we_ok = bus.m_mtc0;
          end
          if ((trap || eret_ret) && FC != 3'd0) begin
            state_nxt = ST_FLUSH;
            cnt_nxt   = FC;
          end
        end
        default: begin
          // M-stage inputs are dead here; only the counter matters
          bus.flush = 1'b1;
          cnt_nxt   = cnt - 3'd1;
          if (cnt <= 3'd1) begin
            state_nxt = ST_RUN;
            cnt_nxt   = '0;
          end
        end
      endcase
    end
  end

`ifdef EXC_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      int_cnt <= '0;
      exc_cnt <= '0;
    end else begin
      if (run && take_int && int_cnt != 16'hFFFF) int_cnt <= int_cnt + 16'd1;
      if (run && take_exc && exc_cnt != 16'hFFFF) exc_cnt <= exc_cnt + 16'd1;
    end
  end
`else
  logic unused_stats;
  assign unused_stats = run & take_int & take_exc;
`endif
endmodule

// File: tb/tb_exc_ctrl.sv
// Directed bench for exc_ctrl; stats checks compile in with EXC_STATS_EN.
module tb_exc_ctrl;
  import exc_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  exc_ctrl_if bus ();
`ifdef EXC_STATS_EN
  logic [15:0] int_cnt, exc_cnt, int_cnt2, exc_cnt2;
  exc_ctrl_if bus2 ();
  exc_ctrl #(.FLUSH_CYCLES(0)) u_sat (
    .clk(clk), .reset(reset), .bus(bus2), .int_cnt(int_cnt2), .exc_cnt(exc_cnt2));
`endif

  exc_ctrl #(.HANDLER_ADDR(32'h0000_4180), .FLUSH_CYCLES(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef EXC_STATS_EN
    , .int_cnt(int_cnt), .exc_cnt(exc_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic idle();
    bus.m_valid = 0; bus.m_pc = '0; bus.m_bd = 0; bus.m_exc_valid = 0;
    bus.m_exc_code = '0; bus.m_eret = 0; bus.m_mtc0 = 0; bus.irq_pend = 0;
    bus.cp0_epc = '0;
  endtask

  // next drive point: just after the active edge
  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    idle();
`ifdef EXC_STATS_EN
    bus2.m_valid = 0; bus2.m_pc = '0; bus2.m_bd = 0; bus2.m_exc_valid = 0;
    bus2.m_exc_code = '0; bus2.m_eret = 0; bus2.m_mtc0 = 0; bus2.irq_pend = 0;
    bus2.cp0_epc = '0;
`endif
    nxt(); nxt();
    // reset: outputs held at zero even with a faulting instruction present
    bus.m_valid = 1; bus.m_exc_valid = 1; bus.m_exc_code = EXC_OV; bus.m_pc = 32'h3000;
    smp();
    check("rst_take", {31'b0, bus.cp0_take}, 0);
    check("rst_flush", {31'b0, bus.flush}, 0);
    check("rst_exc", {26'b0, bus.cp0_exc}, 0);
    check("rst_rpc", bus.redirect_pc, 32'h4180);
    check("rst_pc", bus.cp0_pc, 0);
    nxt(); reset = 1'b0; idle();

    // Ov trap
    bus.m_valid = 1; bus.m_pc = 32'h3010; bus.m_exc_valid = 1; bus.m_exc_code = EXC_OV;
    smp();
    check("ov_exc", {26'b0, bus.cp0_exc}, 32'h2C);
    check("ov_pc", bus.cp0_pc, 32'h3010);
    check("ov_take", {31'b0, bus.cp0_take}, 1);
    check("ov_rpc", bus.redirect_pc, 32'h4180);
    check("ov_redir", {31'b0, bus.redirect}, 1);
    check("ov_kill", {31'b0, bus.mem_kill}, 1);
    check("ov_flush0", {31'b0, bus.flush}, 1);
    nxt();
    smp();
    check("ov_flush1", {31'b0, bus.flush}, 1);
    check("ov_take1", {31'b0, bus.cp0_take}, 0);
    check("ov_redir1", {31'b0, bus.redirect}, 0);
    nxt(); idle();
    smp();
    check("ov_flush2", {31'b0, bus.flush}, 0);

    // pending interrupt waits for a valid instruction
    nxt(); bus.irq_pend = 1;
    for (int i = 0; i < 3; i++) begin
      smp();
      check("irq_bubble_take", {31'b0, bus.cp0_take}, 0);
      check("irq_bubble_flush", {31'b0, bus.flush}, 0);
      nxt();
    end
    bus.m_valid = 1; bus.m_pc = 32'h3020; bus.m_bd = 1;
    smp();
    check("irq_take", {31'b0, bus.cp0_take}, 1);
    check("irq_exc", {26'b0, bus.cp0_exc}, 0);
    check("irq_bd", {31'b0, bus.cp0_bd}, 1);
    check("irq_pc", bus.cp0_pc, 32'h3020);
    nxt();
    smp();
    check("irq_fl_take", {31'b0, bus.cp0_take}, 0);
    check("irq_fl_bd", {31'b0, bus.cp0_bd}, 0);
    nxt(); idle();

    // interrupt and AdES together
    bus.m_valid = 1; bus.irq_pend = 1; bus.m_exc_valid = 1; bus.m_exc_code = EXC_ADES;
    bus.m_pc = 32'h3030;
    smp();
    check("both_exc", {26'b0, bus.cp0_exc}, 0);
    check("both_take", {31'b0, bus.cp0_take}, 1);
    nxt();
    smp();
    check("both_fl_take", {31'b0, bus.cp0_take}, 0);
    check("both_fl_flush", {31'b0, bus.flush}, 1);
    nxt(); idle();

    // eret without interrupt
    bus.m_valid = 1; bus.m_eret = 1; bus.m_pc = 32'h4200; bus.cp0_epc = 32'h3024;
    smp();
    check("eret_clr", {31'b0, bus.exl_clr}, 1);
    check("eret_rpc", bus.redirect_pc, 32'h3024);
    check("eret_take", {31'b0, bus.cp0_take}, 0);
    check("eret_flush", {31'b0, bus.flush}, 1);
    check("eret_redir", {31'b0, bus.redirect}, 1);
    nxt();
    smp();
    check("eret_fl_clr", {31'b0, bus.exl_clr}, 0);
    check("eret_fl_flush", {31'b0, bus.flush}, 1);
    nxt();
    // eret with interrupt: trap wins
    bus.irq_pend = 1;
    smp();
    check("eret_irq_take", {31'b0, bus.cp0_take}, 1);
    check("eret_irq_clr", {31'b0, bus.exl_clr}, 0);
    check("eret_irq_rpc", bus.redirect_pc, 32'h4180);
    check("eret_irq_pc", bus.cp0_pc, 32'h4200);
    nxt(); idle();
    nxt();

    // mtc0 permission
    bus.m_valid = 1; bus.m_mtc0 = 1;
    smp();
    check("mtc0_ok", {31'b0, bus.cp0_we_ok}, 1);
    nxt(); bus.irq_pend = 1;
    smp();
    check("mtc0_irq_ok", {31'b0, bus.cp0_we_ok}, 0);
    check("mtc0_irq_take", {31'b0, bus.cp0_take}, 1);
    nxt(); bus.irq_pend = 0;
    smp();
    check("mtc0_fl_ok", {31'b0, bus.cp0_we_ok}, 0);
    // reset while flushing
    nxt(); bus.irq_pend = 1; bus.m_mtc0 = 0;
    smp();
    check("pre_rst_take", {31'b0, bus.cp0_take}, 1);
    nxt(); reset = 1'b1; idle();
    smp();
    check("rstfl_flush", {31'b0, bus.flush}, 0);
    nxt(); reset = 1'b0;
    smp();
    check("post_rst_flush", {31'b0, bus.flush}, 0);
    check("post_rst_redir", {31'b0, bus.redirect}, 0);
    check("post_rst_rpc", bus.redirect_pc, 32'h4180);
    nxt();

`ifdef EXC_STATS_EN
    check("cnt_rst_int", {16'b0, int_cnt}, 0);
    for (int i = 0; i < 2; i++) begin
      bus.m_valid = 1; bus.irq_pend = 1; nxt(); idle(); nxt();
    end
    for (int i = 0; i < 3; i++) begin
      bus.m_valid = 1; bus.m_exc_valid = 1; bus.m_exc_code = EXC_RI; nxt(); idle(); nxt();
    end
    smp();
    check("int_cnt", {16'b0, int_cnt}, 2);
    check("exc_cnt", {16'b0, exc_cnt}, 3);
    nxt();
    bus2.m_valid = 1; bus2.m_exc_valid = 1; bus2.m_exc_code = EXC_ADEL;
    repeat (100) @(posedge clk);
    #1;
    check("sat_100", {16'b0, exc_cnt2}, 100);
    repeat (65437) @(posedge clk);
    #1;
    check("sat_max", {16'b0, exc_cnt2}, 32'hFFFF);
    repeat (3) @(posedge clk);
    #1;
    check("sat_hold", {16'b0, exc_cnt2}, 32'hFFFF);
    check("sat_int", {16'b0, int_cnt2}, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
